// File: rtl/dual_port_ram_param_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_param_if
// Bus bundle for the parametrised true dual-port RAM.
//   Port A : ena, wra, address_a, dina -> douta, valida
//   Port B : enb, wrb, address_b, dinb -> doutb, validb
//   Control: clear (request array zeroing) -> busy, collision
// master : the block issuing requests (datapath / testbench)
// slave  : the RAM itself
// -----------------------------------------------------------------------------
interface dual_port_ram_param_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic              ena;
    logic              wra;
    logic [ADDR_W-1:0] address_a;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              valida;

    logic              enb;
    logic              wrb;
    logic [ADDR_W-1:0] address_b;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;
    logic              validb;

    logic              clear;
    logic              busy;
    logic              collision;

    modport master (
        output ena, wra, address_a, dina,
        output enb, wrb, address_b, dinb,
        output clear,
        input  douta, valida, doutb, validb, busy, collision
    );

    modport slave (
        input  ena, wra, address_a, dina,
        input  enb, wrb, address_b, dinb,
        input  clear,
        output douta, valida, doutb, validb, busy, collision
    );
endinterface

// File: rtl/dual_port_ram_param.sv
// -----------------------------------------------------------------------------
// dual_port_ram_param
// Single-clock true dual-port RAM with a hardware clear engine.
//   clk  : rising-edge clock for all logic
//   rst  : asynchronous active-high reset; starts a clear sweep
//   bus  : dual_port_ram_param_if.slave
//          two read/write ports with read-valid strobes, clear request,
//          busy (clear sweep running) and collision (both ports wrote the
//          same address; port A data kept).
// Parameters:
//   DATA_W    : word width
//   ADDR_W    : address width, DEPTH = 2**ADDR_W
//   OUT_REG   : 0 = read latency 1, 1 = extra output register (latency 2)
//   READ_MODE : cross-port same-address read during a write:
//               0 = old data, 1 = writer's data
// -----------------------------------------------------------------------------
module dual_port_ram_param #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 2,
    parameter int OUT_REG   = 0,
    parameter int READ_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    dual_port_ram_param_if.slave bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy;
    logic              idle;

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CLEAR);
        idle = ~busy;
    end

    // ------------------------------------------------------ port decoding ---
    logic              rd_a, rd_b, wr_a, wr_b;
    logic              same_addr, coll;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    always_comb begin
        rd_a      = idle & bus.ena & ~bus.wra;
        wr_a      = idle & bus.ena &  bus.wra;
        rd_b      = idle & bus.enb & ~bus.wrb;
        wr_b      = idle & bus.enb &  bus.wrb;
        same_addr = (bus.address_a == bus.address_b);
        coll      = wr_a & wr_b & same_addr;

        // Array read returns pre-edge contents (read-first); write-first mode
        // forwards the other port's write data on an address match.
        rdata_a = mem[bus.address_a];
        rdata_b = mem[bus.address_b];
        if (READ_MODE != 0) begin
            if (wr_b && same_addr) rdata_a = bus.dinb;
            if (wr_a && same_addr) rdata_b = bus.dina;
        end
    end

    // ------------------------------------------------------------ storage ---
    logic              we_a, we_b;
    logic [ADDR_W-1:0] waddr_a;
    logic [DATA_W-1:0] wdata_a;

    always_comb begin
        we_a    = wr_a;
        waddr_a = bus.address_a;
        wdata_a = bus.dina;
        // Port A wins a same-address write; B's word is dropped.
        we_b    = wr_b & ~coll;
        // The clear sweep borrows port A's write path.
        if (busy) begin
            we_a    = 1'b1;
            waddr_a = ptr_q;
            wdata_a = '0;
        end
    end

    // NOTE: the storage array has no reset; the clear engine zeroes it so
    // it can still map onto a plain synchronous RAM macro.
    always_ff @(posedge clk) begin
        if (we_a) mem[waddr_a]       <= wdata_a;
        if (we_b) mem[bus.address_b] <= bus.dinb;
    end

    // ------------------------------------------------------- output stage ---
    logic [DATA_W-1:0] douta_q, douta_d, doutb_q, doutb_d;
    logic              valida_q, valida_d, validb_q, validb_d;
    logic              collision_q, collision_d;

    always_comb begin
        collision_d = coll;
    end

    generate
        if (OUT_REG == 0) begin : g_lat1
            always_comb begin
                valida_d = rd_a;
                validb_d = rd_b;
                douta_d  = rd_a ? rdata_a : douta_q;
                doutb_d  = rd_b ? rdata_b : doutb_q;
            end
        end else begin : g_lat2
            // Stage 1 captures the read; stage 2 presents it. Stage 2 keeps
            // running while busy so a read in flight at clear still lands.
            logic [DATA_W-1:0] s1_data_a_q, s1_data_a_d, s1_data_b_q, s1_data_b_d;
            logic              s1_valid_a_q, s1_valid_a_d, s1_valid_b_q, s1_valid_b_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_data_a_q  <= '0;
                    s1_data_b_q  <= '0;
                    s1_valid_a_q <= 1'b0;
                    s1_valid_b_q <= 1'b0;
                end else begin
                    s1_data_a_q  <= s1_data_a_d;
                    s1_data_b_q  <= s1_data_b_d;
                    s1_valid_a_q <= s1_valid_a_d;
                    s1_valid_b_q <= s1_valid_b_d;
                end
            end

            always_comb begin
                s1_valid_a_d = rd_a;
                s1_valid_b_d = rd_b;
                s1_data_a_d  = rd_a ? rdata_a : s1_data_a_q;
                s1_data_b_d  = rd_b ? rdata_b : s1_data_b_q;
                valida_d     = s1_valid_a_q;
                validb_d     = s1_valid_b_q;
                douta_d      = s1_valid_a_q ? s1_data_a_q : douta_q;
                doutb_d      = s1_valid_b_q ? s1_data_b_q : doutb_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            douta_q     <= '0;
            doutb_q     <= '0;
            valida_q    <= 1'b0;
            validb_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            douta_q     <= douta_d;
            doutb_q     <= doutb_d;
            valida_q    <= valida_d;
            validb_q    <= validb_d;
            collision_q <= collision_d;
        end
    end

    assign bus.douta     = douta_q;
    assign bus.valida    = valida_q;
    assign bus.doutb     = doutb_q;
    assign bus.validb    = validb_q;
    assign bus.busy      = busy;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_param
// Self-checking bench for dual_port_ram_param (DATA_W=8, ADDR_W=4).
// A behavioural model (plain array + busy countdown + latency delay line)
// predicts every output each cycle; a vector table and hand-written
// sequences cover the collision, cross-port and clear/reset corner cases.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_param #(
    parameter int OUT_REG   = 0,
    parameter int READ_MODE = 0
);
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NV    = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_port_ram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dual_port_ram_param #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .OUT_REG  (OUT_REG),
        .READ_MODE(READ_MODE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // ------------------------------------------------------------- model ---
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    rd_t           q_a[$];
    rd_t           q_b[$];
    int            m_busy_left;
    logic [DW-1:0] m_douta, m_doutb;
    logic          m_valida, m_validb, m_coll;

    task automatic m_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_busy_left = DEPTH;
        m_douta = '0; m_doutb = '0;
        m_valida = 1'b0; m_validb = 1'b0; m_coll = 1'b0;
        q_a.delete(); q_b.delete();
        for (int i = 0; i < OUT_REG; i++) begin
            q_a.push_back('0);
            q_b.push_back('0);
        end
    endtask

    task automatic m_cycle(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                           input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                           input logic clr);
        bit            serve = (m_busy_left == 0);
        bit            ra = serve && ea && !wa;
        bit            xa = serve && ea &&  wa;
        bit            rb = serve && eb && !wb;
        bit            xb = serve && eb &&  wb;
        logic [DW-1:0] va = m_mem[aa];
        logic [DW-1:0] vb = m_mem[ab];
        rd_t           pa, pb;
        if (READ_MODE == 1) begin
            if (xb && ab == aa) va = db;
            if (xa && aa == ab) vb = da;
        end
        m_coll = xa && xb && (aa == ab);
        if (xb) m_mem[ab] = db;
        if (xa) m_mem[aa] = da;          // port A has the last word
        if (!serve) m_busy_left--;
        else if (clr) begin
            m_busy_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = '0;
        end
        q_a.push_back('{v: ra, d: va});
        q_b.push_back('{v: rb, d: vb});
        pa = q_a.pop_front();
        pb = q_b.pop_front();
        m_valida = pa.v;
        m_validb = pb.v;
        if (pa.v) m_douta = pa.d;
        if (pb.v) m_doutb = pb.d;
    endtask

    // ---------------------------------------------------------- stimulus ---
    task automatic drive(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic clr);
        bus.ena = ea; bus.wra = wa; bus.address_a = aa; bus.dina = da;
        bus.enb = eb; bus.wrb = wb; bus.address_b = ab; bus.dinb = db;
        bus.clear = clr;
    endtask

    task automatic step(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        input logic clr);
        drive(ea, wa, aa, da, eb, wb, ab, db, clr);
        m_cycle(ea, wa, aa, da, eb, wb, ab, db, clr);
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("cycle%0d", cyc),
              64'({bus.douta, bus.valida, bus.doutb, bus.validb, bus.busy, bus.collision}),
              64'({m_douta, m_valida, m_doutb, m_validb, m_busy_left != 0, m_coll}));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < OUT_REG; k++) idle_step();
    endtask

    // Counts cycles until busy drops; optionally fires port writes that the
    // sweep must ignore.
    task automatic sweep_wait(input bit poke, output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 4 * DEPTH) begin
            if (poke) step(1'b1, 1'b1, 4'(cnt), 8'hEE, 1'b1, 1'b1, 4'(cnt + 8), 8'hDD, 1'b0);
            else      idle_step();
            cnt++;
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 8'(i * 37 + 1);
    endfunction

    // ------------------------------------------------------- vector table ---
    typedef struct {
        logic          ea, wa;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          eb, wb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic [DW-1:0] xa;
        logic          xva;
        logic [DW-1:0] xb;
        logic          xvb;
        logic          xc;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int cnt;

        vecs[0]  = '{1'b1,1'b1,4'd3,8'hA5, 1'b0,1'b0,4'd0,8'h00, 8'h00,1'b0, 8'h00,1'b0, 1'b0};
        vecs[1]  = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd3,8'h00, 8'h00,1'b0, 8'hA5,1'b1, 1'b0};
        vecs[2]  = '{1'b1,1'b1,4'd7,8'h11, 1'b0,1'b0,4'd0,8'h00, 8'h00,1'b0, 8'hA5,1'b0, 1'b0};
        vecs[3]  = '{1'b1,1'b1,4'd7,8'h3C, 1'b1,1'b0,4'd7,8'h00, 8'h00,1'b0,
                     (READ_MODE == 1) ? 8'h3C : 8'h11, 1'b1, 1'b0};
        vecs[4]  = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd7,8'h00, 8'h00,1'b0, 8'h3C,1'b1, 1'b0};
        vecs[5]  = '{1'b1,1'b1,4'd2,8'h55, 1'b1,1'b1,4'd2,8'hAA, 8'h00,1'b0, 8'h3C,1'b0, 1'b1};
        vecs[6]  = '{1'b1,1'b0,4'd2,8'h00, 1'b0,1'b0,4'd0,8'h00, 8'h55,1'b1, 8'h3C,1'b0, 1'b0};
        vecs[7]  = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd2,8'h00, 8'h55,1'b0, 8'h55,1'b1, 1'b0};
        vecs[8]  = '{1'b1,1'b0,4'd3,8'h00, 1'b1,1'b0,4'd3,8'h00, 8'hA5,1'b1, 8'hA5,1'b1, 1'b0};
        vecs[9]  = '{1'b1,1'b1,4'd5,8'h12, 1'b1,1'b1,4'd6,8'h34, 8'hA5,1'b0, 8'hA5,1'b0, 1'b0};
        vecs[10] = '{1'b1,1'b0,4'd6,8'h00, 1'b1,1'b0,4'd5,8'h00, 8'h34,1'b1, 8'h12,1'b1, 1'b0};
        vecs[11] = '{1'b0,1'b1,4'd5,8'hFF, 1'b0,1'b1,4'd6,8'hFF, 8'h34,1'b0, 8'h12,1'b0, 1'b0};
        vecs[12] = '{1'b1,1'b0,4'd5,8'h00, 1'b1,1'b0,4'd6,8'h00, 8'h12,1'b1, 8'h34,1'b1, 1'b0};

        // Power-on reset and first sweep.
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({bus.douta, bus.valida, bus.doutb, bus.validb, bus.collision, bus.busy}),
              64'({8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
        rst = 1'b0;
        sweep_wait(1'b0, cnt);
        check("reset_sweep_len", 64'(cnt), 64'(DEPTH));

        // Whole array reads back zero on port A.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        drain();

        // Table vectors; each op gets its full latency before comparing.
        for (int i = 0; i < NV; i++) begin
            logic c;
            step(vecs[i].ea, vecs[i].wa, vecs[i].aa, vecs[i].da,
                 vecs[i].eb, vecs[i].wb, vecs[i].ab, vecs[i].db, 1'b0);
            c = bus.collision;
            drain();
            check($sformatf("vec%0d", i),
                  64'({bus.douta, bus.valida, bus.doutb, bus.validb, c}),
                  64'({vecs[i].xa, vecs[i].xva, vecs[i].xb, vecs[i].xvb, vecs[i].xc}));
        end

        // Back-to-back reads on both ports.
        step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
        step(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        drain();
        idle_step();

        // Fill, then clear with a read issued in the accepting cycle.
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b1, 4'(2 * i), pat(2 * i), 1'b1, 1'b1, 4'(2 * i + 1), pat(2 * i + 1), 1'b0);
        step(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        sweep_wait(1'b1, cnt);
        check("clear_sweep_len", 64'(cnt), 64'(DEPTH));
        check("clear_pending_read", 64'(bus.douta), 64'(pat(9)));
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'(DEPTH - 1 - i), 8'h00, 1'b0);
        drain();
        check("clear_zeroed", 64'({bus.douta, bus.doutb}), 64'h0);

        // Reset at sweep cycle 5 restarts the sweep.
        step(1'b1, 1'b1, 4'd0, 8'h77, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        drain();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        repeat (4) idle_step();
        rst = 1'b1;
        #1;
        check("rst_async",
              64'({bus.douta, bus.valida, bus.doutb, bus.validb, bus.collision, bus.busy}),
              64'({8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep_wait(1'b0, cnt);
        check("rst_sweep_len", 64'(cnt), 64'(DEPTH));
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        drain();
        check("rst_zeroed", 64'({bus.douta, bus.valida}), 64'({8'h00, 1'b1}));

        // Randomised traffic, biased towards shared addresses.
        for (int n = 0; n < 600; n++) begin
            logic          ea, wa, eb, wb, clr;
            logic [AW-1:0] aa, ab;
            ea  = ($urandom_range(0, 3) != 0);
            wa  = ($urandom_range(0, 1) != 0);
            eb  = ($urandom_range(0, 3) != 0);
            wb  = ($urandom_range(0, 1) != 0);
            aa  = 4'($urandom_range(0, DEPTH - 1));
            ab  = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, DEPTH - 1));
            clr = ($urandom_range(0, 79) == 0);
            step(ea, wa, aa, 8'($urandom), eb, wb, ab, 8'($urandom), clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
